// File: rtl/mtl_pixel_fetch.sv
// -----------------------------------------------------------------------------
// mtl_pixel_fetch
// Upstream feeder of the MTL LCD controller. Prefetches one frame of 32-bit
// pixels (0x00RRGGBB) from SDRAM into a local FIFO using burst read requests.
// Each LCD read enable pops one pixel with a fixed 1-cycle latency. A
// new-frame pulse restarts fetching at the frame base address.
//
// Ports
//   iCLK               pixel/system clock, rising edge
//   iRST_n             asynchronous active-low reset
//   iNewFrame          1-cycle pulse at LCD frame start
//   iFRAME_BASE        frame start word address, sampled on iNewFrame
//   iREAD_EN           LCD pops one pixel this cycle
//   oREAD_DATA         popped pixel, valid the cycle after iREAD_EN
//   oUnderflow         sticky: a pop found the FIFO empty this frame
//   oSDRAM_RD_REQ      burst read request, held until acknowledged
//   oSDRAM_ADDR        burst start word address, stable while REQ is high
//   iSDRAM_RD_ACK      request accepted this cycle
//   iSDRAM_DATA_VALID  one returned burst word this cycle
//   iSDRAM_DATA        returned word, in address order
// -----------------------------------------------------------------------------
module mtl_pixel_fetch #(
    parameter int ADDR_W      = 24,
    parameter int FRAME_WORDS = 384000,
    parameter int BURST_LEN   = 8,
    parameter int FIFO_AW     = 6
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic              iNewFrame,
    input  logic [ADDR_W-1:0] iFRAME_BASE,
    input  logic              iREAD_EN,
    output logic [31:0]       oREAD_DATA,
    output logic              oUnderflow,
    output logic              oSDRAM_RD_REQ,
    output logic [ADDR_W-1:0] oSDRAM_ADDR,
    input  logic              iSDRAM_RD_ACK,
    input  logic              iSDRAM_DATA_VALID,
    input  logic [31:0]       iSDRAM_DATA
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int REQ_W = $clog2(FRAME_WORDS + 1);
    localparam int CNT_W = FIFO_AW + 1;

    // Constants pre-sized to the counters they are combined with.
    localparam logic [CNT_W:0]    DEPTH_EXT = DEPTH[CNT_W:0];
    localparam logic [CNT_W:0]    BL_EXT    = BURST_LEN[CNT_W:0];
    localparam logic [CNT_W-1:0]  BL_CNT    = BURST_LEN[CNT_W-1:0];
    localparam logic [REQ_W-1:0]  BL_REQ    = BURST_LEN[REQ_W-1:0];
    localparam logic [REQ_W-1:0]  FW_REQ    = FRAME_WORDS[REQ_W-1:0];
    localparam logic [ADDR_W-1:0] BL_ADDR   = BURST_LEN[ADDR_W-1:0];
    localparam logic [CNT_W-1:0]  DEPTH_CNT = DEPTH[CNT_W-1:0];

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               req_q, req_d;
    logic [ADDR_W-1:0]  addr_q;
    logic [REQ_W-1:0]   requested_q;
    logic [CNT_W-1:0]   inflight_q, inflight_nxt;
    logic [CNT_W-1:0]   discard_q;
    logic [CNT_W-1:0]   count_q;
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [31:0]        read_data_q;
    logic               underflow_q;
    logic [31:0]        mem [DEPTH];

    logic ack_take;
    logic beat_valid;
    logic push, pop, empty;
    logic credit_ok, more_to_fetch, last_burst;

    assign ack_take      = req_q & iSDRAM_RD_ACK;
    // A beat with nothing in flight is a leftover from before a reset and is
    // ignored so it cannot corrupt the counters or the FIFO.
    assign beat_valid    = iSDRAM_DATA_VALID & (inflight_q != '0);
    assign empty         = (count_q == '0);
    // A new frame flushes the FIFO, so neither a push nor a pop survives it.
    assign push          = beat_valid & (discard_q == '0) & (count_q != DEPTH_CNT) & ~iNewFrame;
    assign pop           = iREAD_EN & ~empty & ~iNewFrame;
    // Only issue a burst when every word already promised still fits.
    assign credit_ok     = ({1'b0, count_q} + {1'b0, inflight_q} + BL_EXT) <= DEPTH_EXT;
    assign more_to_fetch = requested_q < FW_REQ;
    assign last_burst    = (requested_q + BL_REQ) == FW_REQ;

    assign inflight_nxt  = inflight_q + (ack_take ? BL_CNT : '0)
                         - {{FIFO_AW{1'b0}}, beat_valid};

    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        req_d   = 1'b0;
        case (state_q)
            IDLE: ;
            FETCH: begin
                if (req_q) begin
                    req_d = ~iSDRAM_RD_ACK;
                end else begin
                    req_d = credit_ok & more_to_fetch;
                end
                if (ack_take && last_burst) begin
                    state_d = DONE;
                end
            end
            DONE: ;
            default: state_d = IDLE;
        endcase
        // A frame restart wins over everything; an outstanding request is
        // withdrawn unless it is being acknowledged in this very cycle.
        if (iNewFrame) begin
            state_d = FETCH;
            req_d   = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            addr_q      <= '0;
            requested_q <= '0;
            inflight_q  <= '0;
            discard_q   <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            read_data_q <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            inflight_q <= inflight_nxt;
            if (iNewFrame) begin
                addr_q      <= iFRAME_BASE;
                requested_q <= '0;
                // Everything still owed by SDRAM belongs to the old frame,
                // including a burst acknowledged in this cycle.
                discard_q   <= inflight_nxt;
                count_q     <= '0;
                wr_ptr_q    <= '0;
                rd_ptr_q    <= '0;
                read_data_q <= '0;
                underflow_q <= 1'b0;
            end else begin
                if (ack_take) begin
                    addr_q      <= addr_q + BL_ADDR;
                    requested_q <= requested_q + BL_REQ;
                end
                if (beat_valid && discard_q != '0) begin
                    discard_q <= discard_q - 1'b1;
                end
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                end
                if (pop) begin
                    rd_ptr_q    <= rd_ptr_q + 1'b1;
                    read_data_q <= mem[rd_ptr_q];
                end else if (iREAD_EN) begin
                    read_data_q <= '0;
                    underflow_q <= 1'b1;
                end
                count_q <= count_q + {{FIFO_AW{1'b0}}, push} - {{FIFO_AW{1'b0}}, pop};
            end
        end
    end

    // NOTE: the storage array has no reset; validity is tracked entirely by
    // the pointers and count, so clearing the words would only cost logic.
    always_ff @(posedge iCLK) begin
        if (push) begin
            mem[wr_ptr_q] <= iSDRAM_DATA;
        end
    end

    assign oREAD_DATA    = read_data_q;
    assign oUnderflow    = underflow_q;
    assign oSDRAM_RD_REQ = req_q;
    assign oSDRAM_ADDR   = addr_q;

endmodule

// File: tb/tb_mtl_pixel_fetch.sv
// -----------------------------------------------------------------------------
// tb_mtl_pixel_fetch
// Directed bench for mtl_pixel_fetch. Instance dut uses the full-size frame;
// instance dut_b uses a 64-word frame to reach the end-of-frame behaviour.
// Each instance has a small SDRAM responder that acknowledges a request on the
// next falling edge and returns address-valued data a few cycles later.
// -----------------------------------------------------------------------------
module tb_mtl_pixel_fetch;

    logic clk;
    logic rst_n;

    // instance A signals
    logic        nf_a, rd_en_a, req_a, ack_a, dv_a, uf_a;
    logic [23:0] base_a, addr_a;
    logic [31:0] rd_a, data_a;
    // instance B signals
    logic        nf_b, rd_en_b, req_b, ack_b, dv_b, uf_b;
    logic [23:0] base_b, addr_b;
    logic [31:0] rd_b, data_b;

    int n_vec  = 0;
    int n_miss = 0;

    // SDRAM responder state
    logic [31:0] q_a[$];
    int          rdy_a[$];
    logic [31:0] ack_log_a[$];
    logic [31:0] q_b[$];
    int          rdy_b[$];
    int          req_cnt_b = 0;
    int          cyc       = 0;
    int          ack_budget = 1000000;
    bit          slow = 1'b0;

    // scoreboard for the underflow test on instance A
    bit          sb_en = 1'b0;
    logic [31:0] sb_q[$];
    logic [31:0] sb_rd = '0;
    logic        sb_uf = 1'b0;

    int ovf_a = 0;
    int ovf_b = 0;

    mtl_pixel_fetch dut (
        .iCLK              (clk),
        .iRST_n            (rst_n),
        .iNewFrame         (nf_a),
        .iFRAME_BASE       (base_a),
        .iREAD_EN          (rd_en_a),
        .oREAD_DATA        (rd_a),
        .oUnderflow        (uf_a),
        .oSDRAM_RD_REQ     (req_a),
        .oSDRAM_ADDR       (addr_a),
        .iSDRAM_RD_ACK     (ack_a),
        .iSDRAM_DATA_VALID (dv_a),
        .iSDRAM_DATA       (data_a)
    );

    mtl_pixel_fetch #(.FRAME_WORDS(64)) dut_b (
        .iCLK              (clk),
        .iRST_n            (rst_n),
        .iNewFrame         (nf_b),
        .iFRAME_BASE       (base_b),
        .iREAD_EN          (rd_en_b),
        .oREAD_DATA        (rd_b),
        .oUnderflow        (uf_b),
        .oSDRAM_RD_REQ     (req_b),
        .oSDRAM_ADDR       (addr_b),
        .iSDRAM_RD_ACK     (ack_b),
        .iSDRAM_DATA_VALID (dv_b),
        .iSDRAM_DATA       (data_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next falling edge (after the responders ran).
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic new_frame_a(input logic [23:0] base);
        nf_a   = 1'b1;
        base_a = base;
        tick();
        nf_a   = 1'b0;
    endtask

    task automatic wait_quiet_a(input string tag);
        int stable = 0;
        for (int i = 0; i < 400 && stable < 4; i++) begin
            tick();
            if (!req_a && !ack_a && !dv_a && q_a.size() == 0) stable++;
            else stable = 0;
        end
        check(tag, stable, 4);
    endtask

    // SDRAM responder, instance A
    initial begin
        int dummy;
        ack_a  = 1'b0;
        dv_a   = 1'b0;
        data_a = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                q_a.delete();
                rdy_a.delete();
                ack_a = 1'b0;
                dv_a  = 1'b0;
            end else begin
                if (ack_a) begin
                    ack_a = 1'b0;
                end else if (req_a && ack_budget > 0) begin
                    ack_a = 1'b1;
                    ack_budget--;
                    ack_log_a.push_back(32'(addr_a));
                    for (int i = 0; i < 8; i++) begin
                        q_a.push_back(32'(addr_a) + 32'(i));
                        rdy_a.push_back(cyc + 4);
                    end
                end
                dv_a = 1'b0;
                if (q_a.size() > 0 && rdy_a[0] <= cyc && (!slow || (cyc % 2 == 0))) begin
                    dv_a   = 1'b1;
                    data_a = q_a.pop_front();
                    dummy  = rdy_a.pop_front();
                end
            end
        end
    end

    // SDRAM responder, instance B
    initial begin
        int dummy;
        ack_b  = 1'b0;
        dv_b   = 1'b0;
        data_b = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q_b.delete();
                rdy_b.delete();
                ack_b = 1'b0;
                dv_b  = 1'b0;
            end else begin
                if (ack_b) begin
                    ack_b = 1'b0;
                end else if (req_b) begin
                    ack_b = 1'b1;
                    req_cnt_b++;
                    for (int i = 0; i < 8; i++) begin
                        q_b.push_back(32'(addr_b) + 32'(i));
                        rdy_b.push_back(cyc + 4);
                    end
                end
                dv_b = 1'b0;
                if (q_b.size() > 0 && rdy_b[0] <= cyc) begin
                    dv_b   = 1'b1;
                    data_b = q_b.pop_front();
                    dummy  = rdy_b.pop_front();
                end
            end
        end
    end

    // Reference FIFO for the underflow test: pop before push in a cycle.
    always @(posedge clk) begin
        if (sb_en) begin
            if (nf_a) begin
                sb_q.delete();
                sb_rd = '0;
                sb_uf = 1'b0;
            end else begin
                if (rd_en_a) begin
                    if (sb_q.size() > 0) begin
                        sb_rd = sb_q.pop_front();
                    end else begin
                        sb_rd = '0;
                        sb_uf = 1'b1;
                    end
                end
                if (dv_a) sb_q.push_back(data_a);
            end
        end
    end

    // A word that would be pushed into a full FIFO must never arrive.
    always @(posedge clk) begin
        if (rst_n && dut.beat_valid && dut.discard_q == '0 && dut.count_q == 7'd64) ovf_a++;
        if (rst_n && dut_b.beat_valid && dut_b.discard_q == '0 && dut_b.count_q == 7'd64) ovf_b++;
    end

    initial begin
        logic [31:0] first_ack;
        rst_n   = 1'b0;
        nf_a    = 1'b0;  base_a = '0;  rd_en_a = 1'b0;
        nf_b    = 1'b0;  base_b = '0;  rd_en_b = 1'b0;
        repeat (3) tick();

        // reset state
        check("rst_rd",   rd_a,   32'h0);
        check("rst_uf",   uf_a,   32'h0);
        check("rst_req",  req_a,  32'h0);
        check("rst_addr", addr_a, 32'h0);
        rst_n = 1'b1;
        repeat (2) tick();

        // T1: asynchronous reset in the middle of fetching
        new_frame_a(24'h000040);
        repeat (15) tick();
        rd_en_a = 1'b1;
        tick();
        check("t1_pop0", rd_a, 32'h40);
        tick();
        check("t1_pop1", rd_a, 32'h41);
        rd_en_a = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("t1_rd",   rd_a,   32'h0);
        check("t1_uf",   uf_a,   32'h0);
        check("t1_req",  req_a,  32'h0);
        check("t1_addr", addr_a, 32'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        check("t1_idle_req", req_a, 32'h0);
        rd_en_a = 1'b1;
        tick();
        rd_en_a = 1'b0;
        check("t1_empty_rd", rd_a, 32'h0);
        check("t1_empty_uf", uf_a, 32'h1);

        // T2: prefill from 0x100 stops once 64 words are buffered or in flight
        ack_log_a.delete();
        new_frame_a(24'h000100);
        check("t2_uf_clr", uf_a, 32'h0);
        repeat (60) tick();
        check("t2_nreq", ack_log_a.size(), 8);
        for (int k = 0; k < 8 && k < ack_log_a.size(); k++) begin
            check($sformatf("t2_addr%0d", k), ack_log_a[k], 32'h100 + 32'(8 * k));
        end
        check("t2_req_low", req_a, 32'h0);

        // T3: ten back-to-back pops, one-cycle latency, address order
        rd_en_a = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("t3_pop%0d", i), rd_a, 32'h100 + 32'(i));
        end
        rd_en_a = 1'b0;
        check("t3_uf", uf_a, 32'h0);
        tick();
        check("t3_hold", rd_a, 32'h109);

        // T4: pop every cycle while SDRAM returns one word per two cycles
        wait_quiet_a("t4_quiet");
        slow  = 1'b1;
        sb_en = 1'b1;
        new_frame_a(24'h000300);
        rd_en_a = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            check($sformatf("t4_pop%0d", i), rd_a, sb_rd);
            check($sformatf("t4_uf%0d", i),  uf_a, 32'(sb_uf));
        end
        rd_en_a = 1'b0;
        sb_en   = 1'b0;
        repeat (5) tick();
        check("t4_uf_sticky", uf_a, 32'h1);

        // T5: restart with five beats of a burst still in flight
        slow = 1'b0;
        wait_quiet_a("t5_quiet");
        ack_budget = 1;
        new_frame_a(24'h000500);
        check("t5_uf_clr", uf_a, 32'h0);
        check("t5_rd_clr", rd_a, 32'h0);
        for (int i = 0; i < 50 && q_a.size() != 5; i++) tick();
        check("t5_inflight", q_a.size(), 5);
        check("t5_req_pend", req_a, 32'h1);
        check("t5_addr_pend", addr_a, 32'h508);
        ack_log_a.delete();
        nf_a       = 1'b1;
        base_a     = 24'h200000;
        ack_budget = 1000000;
        tick();
        nf_a = 1'b0;
        check("t5_req_drop", req_a, 32'h0);
        repeat (25) tick();
        first_ack = (ack_log_a.size() > 0) ? ack_log_a[0] : 32'hDEAD_BEEF;
        check("t5_first_req", first_ack, 32'h200000);
        rd_en_a = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("t5_pop%0d", i), rd_a, 32'h200000 + 32'(i));
        end
        rd_en_a = 1'b0;
        check("t5_uf", uf_a, 32'h0);

        // T6: 64-word frame, continuous popping through the end of the frame
        nf_b   = 1'b1;
        base_b = 24'h001000;
        tick();
        nf_b = 1'b0;
        repeat (20) tick();
        rd_en_b = 1'b1;
        for (int i = 0; i < 64; i++) begin
            tick();
            check($sformatf("t6_pop%0d", i), rd_b, 32'h1000 + 32'(i));
        end
        check("t6_uf_before", uf_b, 32'h0);
        tick();
        rd_en_b = 1'b0;
        check("t6_empty_rd", rd_b, 32'h0);
        check("t6_empty_uf", uf_b, 32'h1);
        repeat (10) tick();
        check("t6_nreq",  req_cnt_b, 8);
        check("t6_req",   req_b, 32'h0);
        check("t6_state", 32'(dut_b.state_q), 32'd2);

        check("no_push_full_a", ovf_a, 0);
        check("no_push_full_b", ovf_b, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
